// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and memory/interconnect (slave).
// req/gnt handshake for address phase, single-cycle rvalid for load data.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus, formats load data and
// registers the MEM/WB result; stalls upstream while a bus access is outstanding.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 rd_addr_i,
    input  logic [31:0]                rd_data_i,
    input  logic                       rd_wen_i,
    input  logic [31:0]                mem_addr_i,
    input  logic [31:0]                mem_data_i,
    input  logic [2:0]                 mem_size_i,
    input  logic                       mem_we_i,
    input  logic                       mem_re_i,
    output logic                       stall_o,
    mem_access_stage_if.master         dbus,
    output logic [4:0]                 wb_rd_addr_o,
    output logic [31:0]                wb_rd_data_o,
    output logic                       wb_rd_wen_o,
    output logic                       misalign_o,
    output logic                       bus_err_o
);
    localparam int unsigned CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    a_q;
    logic [2:0]    size_q;
    logic          we_q;

    logic          access, is_store, illegal, legal_access, misalign;
    logic          req, stall, timeout, hs, load_done;
    logic [31:0]   lane, fmt;
    logic          sext;

    assign access       = mem_we_i | mem_re_i;
    assign is_store     = mem_we_i;
    assign legal_access = access & ~illegal;
    assign misalign     = (state == IDLE) & access & illegal;

    always_comb begin
        illegal = 1'b0;
        case (mem_size_i)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = mem_addr_i[0];
            3'b010:         illegal = |mem_addr_i[1:0];
            default:        illegal = 1'b1;
        endcase
    end

    // Bus request fields come straight from the held upstream inputs.
    always_comb begin
        dbus.req   = req;
        dbus.we    = is_store;
        dbus.addr  = {mem_addr_i[31:2], 2'b00};
        dbus.be    = 4'b1111;
        dbus.wdata = mem_data_i;
        case (mem_size_i[1:0])
            2'b00: begin
                dbus.be    = 4'b0001 << mem_addr_i[1:0];
                dbus.wdata = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                dbus.be    = 4'b0011 << mem_addr_i[1:0];
                dbus.wdata = {2{mem_data_i[15:0]}};
            end
            default: begin
                dbus.be    = 4'b1111;
                dbus.wdata = mem_data_i;
            end
        endcase
    end

    // A store handshaking in REQ completes that cycle, so it releases the stall
    // like a same-cycle store in IDLE; otherwise the held store would re-issue.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req       = 1'b0;
        stall     = 1'b0;
        timeout   = 1'b0;
        hs        = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (legal_access) begin
                    req = 1'b1;
                    if (dbus.gnt) begin
                        hs = 1'b1;
                        if (!is_store) begin
                            state_d = RSP;
                            cnt_d   = '0;
                            stall   = 1'b1;
                        end
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        stall   = 1'b1;
                    end
                end
            end
            REQ: begin
                req = 1'b1;
                if (dbus.gnt) begin
                    hs = 1'b1;
                    if (is_store) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RSP;
                        cnt_d   = '0;
                        stall   = 1'b1;
                    end
                end else if (cnt == LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt + 1'b1;
                end
            end
            RSP: begin
                if (dbus.rvalid) begin
                    load_done = ~we_q;
                    state_d   = IDLE;
                end else if (cnt == LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o = stall;

    assign sext = ~size_q[2];
    assign lane = dbus.rdata >> {a_q, 3'b000};

    always_comb begin
        fmt = lane;
        case (size_q[1:0])
            2'b00:   fmt = {{24{sext & lane[7]}}, lane[7:0]};
            2'b01:   fmt = {{16{sext & lane[15]}}, lane[15:0]};
            default: fmt = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (hs) begin
                a_q    <= mem_addr_i[1:0];
                size_q <= mem_size_i;
                we_q   <= is_store;
            end
        end
    end

    // Stalled edges insert a bubble: write enable drops, address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_addr_o <= '0;
            wb_rd_data_o <= '0;
            wb_rd_wen_o  <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            misalign_o <= misalign;
            bus_err_o  <= timeout;
            if (!stall) begin
                wb_rd_addr_o <= rd_addr_i;
                wb_rd_data_o <= load_done ? fmt : rd_data_i;
                wb_rd_wen_o  <= rd_wen_i & ~misalign & ~timeout;
            end else begin
                wb_rd_wen_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: single-cycle vector table plus
// multi-cycle load, timeout and reset sequences (MAX_WAIT = 4).
module tb_mem_access_stage;
    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [2:0]  mem_size_i;
    logic        mem_we_i;
    logic        mem_re_i;
    logic        stall_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        wb_rd_wen_o;
    logic        misalign_o;
    logic        bus_err_o;

    int unsigned n_total;
    int unsigned n_pass;

    mem_access_stage_if dbus ();

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_wen_i     (rd_wen_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .mem_size_i   (mem_size_i),
        .mem_we_i     (mem_we_i),
        .mem_re_i     (mem_re_i),
        .stall_o      (stall_o),
        .dbus         (dbus),
        .wb_rd_addr_o (wb_rd_addr_o),
        .wb_rd_data_o (wb_rd_data_o),
        .wb_rd_wen_o  (wb_rd_wen_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdd;
        logic        wen;
        logic [31:0] ma;
        logic [31:0] md;
        logic [2:0]  sz;
        logic        we;
        logic        re;
        logic        gnt;
        logic        x_stall;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic        x_mis;
        logic [31:0] x_wbd;
        logic        x_wbw;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic [31:0] rdd, input logic wen,
                          input logic [31:0] ma, input logic [2:0] sz, input logic we, input logic re);
        rd_addr_i  = rd;
        rd_data_i  = rdd;
        rd_wen_i   = wen;
        mem_addr_i = ma;
        mem_data_i = 32'h0;
        mem_size_i = sz;
        mem_we_i   = we;
        mem_re_i   = re;
    endtask

    // gnt_wait: cycles with gnt low before the grant; rv_wait: RSP cycles before rvalid.
    task automatic load_seq(input string nm, input logic [31:0] addr, input logic [2:0] sz,
                            input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                            input logic [31:0] exp);
        set_op(5'd3, 32'h999, 1'b1, addr, sz, 1'b0, 1'b1);
        dbus.gnt = 1'b0;
        for (int c = 0; c < gnt_wait; c++) begin
            #2 chk({nm, "_reqwait_stall"}, 32'(stall_o), 32'd1);
            tick();
        end
        dbus.gnt = 1'b1;
        #2 chk({nm, "_gnt_stall"}, 32'(stall_o), 32'd1);
        chk({nm, "_gnt_req"}, 32'(dbus.req), 32'd1);
        tick();
        dbus.gnt = 1'b0;
        chk({nm, "_bubble_wen"}, 32'(wb_rd_wen_o), 32'd0);
        for (int c = 0; c < rv_wait; c++) begin
            #2 chk({nm, "_rsp_stall"}, 32'(stall_o), 32'd1);
            chk({nm, "_rsp_req"}, 32'(dbus.req), 32'd0);
            tick();
        end
        dbus.rvalid = 1'b1;
        dbus.rdata  = rdata;
        #2 chk({nm, "_rvalid_stall"}, 32'(stall_o), 32'd0);
        tick();
        dbus.rvalid = 1'b0;
        dbus.rdata  = 32'h0;
        chk({nm, "_wb_data"}, wb_rd_data_o, exp);
        chk({nm, "_wb_wen"}, 32'(wb_rd_wen_o), 32'd1);
        chk({nm, "_wb_addr"}, 32'(wb_rd_addr_o), 32'd3);
        chk({nm, "_bus_err"}, 32'(bus_err_o), 32'd0);
        set_op(5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        //            rd     rdd            wen   ma             md             sz      we    re    gnt   stall req   we    addr           be       wdata          mis   wbd            wbw
        vecs[0]  = '{5'd5,  32'h0000_1234, 1'b1, 32'h0000_0000, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 32'h0000_1234, 1'b1};
        vecs[1]  = '{5'd7,  32'h0000_0055, 1'b1, 32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0000_0055, 1'b1};
        vecs[2]  = '{5'd0,  32'h0,         1'b0, 32'h0000_0202, 32'h1234_CDEF, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{5'd0,  32'h0,         1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
        vecs[4]  = '{5'd4,  32'h0000_0011, 1'b1, 32'h0000_0101, 32'h0,         3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_0011, 1'b0};
        vecs[5]  = '{5'd6,  32'h0000_0022, 1'b1, 32'h0000_0102, 32'h0,         3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_0022, 1'b0};
        vecs[6]  = '{5'd8,  32'h0000_0033, 1'b1, 32'h0000_0000, 32'h0,         3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_0033, 1'b0};
        vecs[7]  = '{5'd0,  32'h0,         1'b0, 32'h0000_0301, 32'h1111_1111, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[8]  = '{5'd1,  32'h0000_0044, 1'b1, 32'h0000_0000, 32'h2222_2222, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_0044, 1'b0};
        vecs[9]  = '{5'd2,  32'h0000_0066, 1'b1, 32'h0000_0101, 32'h0000_005A, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0000_0066, 1'b1};
        vecs[10] = '{5'd31, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0,         3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{5'd9,  32'h0000_0099, 1'b1, 32'h0000_0100, 32'h0000_0012, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0001, 32'h1212_1212, 1'b0, 32'h0000_0099, 1'b1};

        rst = 1'b1;
        set_op(5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = 32'h0;
        tick();
        tick();
        chk("rst_wb_addr", 32'(wb_rd_addr_o), 32'd0);
        chk("rst_wb_data", wb_rd_data_o, 32'd0);
        chk("rst_wb_wen", 32'(wb_rd_wen_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rd_addr_i  = vecs[i].rd;
            rd_data_i  = vecs[i].rdd;
            rd_wen_i   = vecs[i].wen;
            mem_addr_i = vecs[i].ma;
            mem_data_i = vecs[i].md;
            mem_size_i = vecs[i].sz;
            mem_we_i   = vecs[i].we;
            mem_re_i   = vecs[i].re;
            dbus.gnt   = vecs[i].gnt;
            #2;
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].x_stall));
            chk($sformatf("v%0d_req", i), 32'(dbus.req), 32'(vecs[i].x_req));
            if (vecs[i].x_req) begin
                chk($sformatf("v%0d_we", i), 32'(dbus.we), 32'(vecs[i].x_we));
                chk($sformatf("v%0d_addr", i), dbus.addr, vecs[i].x_addr);
                chk($sformatf("v%0d_be", i), 32'(dbus.be), 32'(vecs[i].x_be));
                chk($sformatf("v%0d_wdata", i), dbus.wdata, vecs[i].x_wdata);
            end
            tick();
            chk($sformatf("v%0d_wb_addr", i), 32'(wb_rd_addr_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wb_data", i), wb_rd_data_o, vecs[i].x_wbd);
            chk($sformatf("v%0d_wb_wen", i), 32'(wb_rd_wen_o), 32'(vecs[i].x_wbw));
            chk($sformatf("v%0d_misalign", i), 32'(misalign_o), 32'(vecs[i].x_mis));
            chk($sformatf("v%0d_bus_err", i), 32'(bus_err_o), 32'd0);
        end
        set_op(5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        dbus.gnt = 1'b0;
        tick();

        load_seq("lb",      32'h0000_0102, 3'b000, 32'h0080_0000, 0, 1, 32'hFFFF_FF80);
        load_seq("lbu",     32'h0000_0102, 3'b100, 32'h0080_0000, 0, 1, 32'h0000_0080);
        load_seq("lh_req",  32'h0000_0206, 3'b001, 32'h8001_0000, 1, 0, 32'hFFFF_8001);
        load_seq("lhu",     32'h0000_0202, 3'b101, 32'h8001_0000, 0, 0, 32'h0000_8001);
        load_seq("lw_gnt_last", 32'h0000_0104, 3'b010, 32'hCAFE_F00D, 4, 0, 32'hCAFE_F00D);
        load_seq("lw_rv_last",  32'h0000_0104, 3'b010, 32'h1357_9BDF, 0, 3, 32'h1357_9BDF);

        // Grant never arrives: four stalled cycles, then abort.
        set_op(5'd4, 32'h0000_0AAA, 1'b1, 32'h0000_0100, 3'b010, 1'b0, 1'b1);
        dbus.gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2 chk($sformatf("to_stall%0d", c), 32'(stall_o), 32'd1);
            tick();
        end
        #2 chk("to_release_stall", 32'(stall_o), 32'd0);
        tick();
        chk("to_bus_err", 32'(bus_err_o), 32'd1);
        chk("to_wb_wen", 32'(wb_rd_wen_o), 32'd0);
        set_op(5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        dbus.gnt    = 1'b1;
        dbus.rvalid = 1'b1;
        #2 chk("to_idle_req", 32'(dbus.req), 32'd0);
        chk("to_idle_stall", 32'(stall_o), 32'd0);
        tick();
        chk("to_bus_err_pulse", 32'(bus_err_o), 32'd0);
        chk("to_idle_wen", 32'(wb_rd_wen_o), 32'd0);
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;

        // Reset while a load waits in RSP.
        set_op(5'd9, 32'h0000_0077, 1'b1, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        set_op(5'd4, 32'h0000_0BBB, 1'b1, 32'h0000_0100, 3'b010, 1'b0, 1'b1);
        dbus.gnt = 1'b1;
        tick();
        dbus.gnt = 1'b0;
        chk("rs_bubble_addr", 32'(wb_rd_addr_o), 32'd9);
        chk("rs_bubble_data", wb_rd_data_o, 32'h0000_0077);
        chk("rs_bubble_wen", 32'(wb_rd_wen_o), 32'd0);
        #2 chk("rs_rsp_stall", 32'(stall_o), 32'd1);
        rst = 1'b1;
        tick();
        set_op(5'd0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        chk("rs_wb_addr", 32'(wb_rd_addr_o), 32'd0);
        chk("rs_wb_data", wb_rd_data_o, 32'd0);
        chk("rs_wb_wen", 32'(wb_rd_wen_o), 32'd0);
        rst = 1'b0;
        set_op(5'd10, 32'h0123_4567, 1'b1, 32'h0, 3'b000, 1'b0, 1'b0);
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'hFFFF_FFFF;
        #2 chk("rs_alu_stall", 32'(stall_o), 32'd0);
        tick();
        dbus.rvalid = 1'b0;
        chk("rs_alu_addr", 32'(wb_rd_addr_o), 32'd10);
        chk("rs_alu_data", wb_rd_data_o, 32'h0123_4567);
        chk("rs_alu_wen", 32'(wb_rd_wen_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
